// File: rtl/decode_stage.sv
// Registered decode stage between IF and EX: one-entry skid buffer, flush, load-use interlock.
// Optional macro DECODE_ILLEGAL_TRAP_EN adds an `illegal` output that halts intake on bad words.
module decode_stage #(
    parameter int unsigned INS_W        = 32,
    parameter int unsigned CON_W        = 20,
    parameter int unsigned STALL_CYCLES = 1,
    parameter int unsigned CNT_W        = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [INS_W-1:0] in_ins,
    input  logic [INS_W-1:0] in_pc,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CON_W-1:0] out_controls,
    output logic [INS_W-1:0] out_ins,
    output logic [INS_W-1:0] out_pc,
    output logic             stall
`ifdef DECODE_ILLEGAL_TRAP_EN
    ,
    output logic             illegal
`endif
);

    // Control word fields, MSB first:
    // reg_write[19] reg_dst[18:17] alu_op[16:13] alu_src[12:11] mem_cs[10] mem_we[9]
    // wb_sel[8:7] pc_sel[6:4] spare[3:0]
    localparam logic       REG_WRITE_EN_F = 1'b0;
    localparam logic       REG_WRITE_EN_T = 1'b1;
    localparam logic [1:0] REG_DST_RT     = 2'd0;
    localparam logic [1:0] REG_DST_RD     = 2'd1;
    localparam logic [3:0] ALU_OP_ADD     = 4'd0;
    localparam logic [3:0] ALU_OP_SUB     = 4'd1;
    localparam logic [3:0] ALU_OP_AND     = 4'd2;
    localparam logic [3:0] ALU_OP_OR      = 4'd3;
    localparam logic [3:0] ALU_OP_SLT     = 4'd4;
    localparam logic [1:0] ALU_SRC_REG    = 2'd0;
    localparam logic [1:0] ALU_SRC_SEXT   = 2'd1;
    localparam logic [1:0] ALU_SRC_ZEXT   = 2'd2;
    localparam logic       MEM_CS_DISABLE = 1'b0;
    localparam logic       MEM_CS_ENABLE  = 1'b1;
    localparam logic       MEM_WE_F       = 1'b0;
    localparam logic       MEM_WE_T       = 1'b1;
    localparam logic [1:0] WB_SEL_ALU     = 2'd0;
    localparam logic [1:0] WB_SEL_MEM     = 2'd1;
    localparam logic [2:0] PC_SEL_SEQ     = 3'd0;
    localparam logic [2:0] PC_SEL_BEQ     = 3'd1;
    localparam logic [2:0] PC_SEL_BNE     = 3'd2;
    localparam logic [2:0] PC_SEL_JUMP    = 3'd3;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;

`ifdef DECODE_ILLEGAL_TRAP_EN
    localparam logic TRAP_EN = 1'b1;
`else
    localparam logic TRAP_EN = 1'b0;
`endif

    function automatic logic [CON_W-1:0] pack_con(
        input logic       rw,
        input logic [1:0] dst,
        input logic [3:0] op,
        input logic [1:0] src,
        input logic       cs,
        input logic       we,
        input logic [1:0] wb,
        input logic [2:0] pcs
    );
        return CON_W'({rw, dst, op, src, cs, we, wb, pcs, 4'b0000});
    endfunction

    localparam logic [CON_W-1:0] CON_NOP = pack_con(REG_WRITE_EN_F, REG_DST_RT, ALU_OP_OR,
        ALU_SRC_REG, MEM_CS_DISABLE, MEM_WE_F, WB_SEL_ALU, PC_SEL_SEQ);

    typedef struct packed {
        logic [CON_W-1:0] con;
        logic             legal;
        logic             uses_rs;
        logic             uses_rt;
        logic             is_lw;
    } dec_t;

    function automatic logic [CON_W-1:0] rtype_con(input logic [3:0] op);
        return pack_con(REG_WRITE_EN_T, REG_DST_RD, op, ALU_SRC_REG, MEM_CS_DISABLE, MEM_WE_F,
            WB_SEL_ALU, PC_SEL_SEQ);
    endfunction

    function automatic dec_t decode(input logic [INS_W-1:0] ins);
        dec_t d;
        d.con     = CON_NOP;
        d.legal   = 1'b1;
        d.uses_rs = 1'b1;
        d.uses_rt = 1'b0;
        d.is_lw   = 1'b0;
        case (ins[31:26])
            OP_RTYPE: begin
                d.uses_rt = 1'b1;
                case (ins[5:0])
                    FN_ADD:  d.con = rtype_con(ALU_OP_ADD);
                    FN_SUB:  d.con = rtype_con(ALU_OP_SUB);
                    FN_AND:  d.con = rtype_con(ALU_OP_AND);
                    FN_OR:   d.con = rtype_con(ALU_OP_OR);
                    FN_SLT:  d.con = rtype_con(ALU_OP_SLT);
                    default: d.legal = 1'b0;
                endcase
            end
            OP_ADDI: d.con = pack_con(REG_WRITE_EN_T, REG_DST_RT, ALU_OP_ADD, ALU_SRC_SEXT,
                MEM_CS_DISABLE, MEM_WE_F, WB_SEL_ALU, PC_SEL_SEQ);
            OP_ORI:  d.con = pack_con(REG_WRITE_EN_T, REG_DST_RT, ALU_OP_OR, ALU_SRC_ZEXT,
                MEM_CS_DISABLE, MEM_WE_F, WB_SEL_ALU, PC_SEL_SEQ);
            OP_LW: begin
                d.is_lw = 1'b1;
                d.con = pack_con(REG_WRITE_EN_T, REG_DST_RT, ALU_OP_ADD, ALU_SRC_SEXT,
                    MEM_CS_ENABLE, MEM_WE_F, WB_SEL_MEM, PC_SEL_SEQ);
            end
            OP_SW: begin
                d.uses_rt = 1'b1;
                d.con = pack_con(REG_WRITE_EN_F, REG_DST_RT, ALU_OP_ADD, ALU_SRC_SEXT,
                    MEM_CS_ENABLE, MEM_WE_T, WB_SEL_ALU, PC_SEL_SEQ);
            end
            OP_BEQ: begin
                d.uses_rt = 1'b1;
                d.con = pack_con(REG_WRITE_EN_F, REG_DST_RT, ALU_OP_SUB, ALU_SRC_REG,
                    MEM_CS_DISABLE, MEM_WE_F, WB_SEL_ALU, PC_SEL_BEQ);
            end
            OP_BNE: begin
                d.uses_rt = 1'b1;
                d.con = pack_con(REG_WRITE_EN_F, REG_DST_RT, ALU_OP_SUB, ALU_SRC_REG,
                    MEM_CS_DISABLE, MEM_WE_F, WB_SEL_ALU, PC_SEL_BNE);
            end
            OP_J: begin
                d.uses_rs = 1'b0;
                d.con = pack_con(REG_WRITE_EN_F, REG_DST_RT, ALU_OP_ADD, ALU_SRC_REG,
                    MEM_CS_DISABLE, MEM_WE_F, WB_SEL_ALU, PC_SEL_JUMP);
            end
            default: d.legal = 1'b0;
        endcase
        if (!d.legal) begin
            d.uses_rs = 1'b0;
            d.uses_rt = 1'b0;
        end
        return d;
    endfunction

    logic             valid_q, valid_d;
    logic             stall_q, stall_d;
    logic [CON_W-1:0] con_q, con_d;
    logic [INS_W-1:0] ins_q, ins_d;
    logic [INS_W-1:0] pc_q, pc_d;
    logic             skid_valid_q, skid_valid_d;
    logic [INS_W-1:0] skid_ins_q, skid_ins_d;
    logic [INS_W-1:0] skid_pc_q, skid_pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             load_valid_q, load_valid_d;
    logic [4:0]       load_rt_q, load_rt_d;
    logic             trap_q, trap_d;
    logic             alive_q;

    logic             out_xfer, out_free, in_xfer;
    logic             cand_valid, cand_hazard, issue, bubble;
    logic [INS_W-1:0] cand_ins, cand_pc;
    logic [4:0]       cand_rs, cand_rt;
    dec_t             cand_dec;

    assign in_ready     = alive_q & ~skid_valid_q & (cnt_q == '0) & ~trap_q;
    assign out_valid    = valid_q;
    assign stall        = stall_q;
    assign out_controls = con_q;
    assign out_ins      = ins_q;
    assign out_pc       = pc_q;
`ifdef DECODE_ILLEGAL_TRAP_EN
    assign illegal      = trap_q;
`endif

    always_comb begin
        out_xfer    = valid_q & out_ready;
        out_free    = ~valid_q | out_ready;
        in_xfer     = in_valid & in_ready;
        // The skid always holds the oldest word, so it is the next to enter the output stage.
        cand_valid  = skid_valid_q | in_xfer;
        cand_ins    = skid_valid_q ? skid_ins_q : in_ins;
        cand_pc     = skid_valid_q ? skid_pc_q : in_pc;
        cand_rs     = cand_ins[25:21];
        cand_rt     = cand_ins[20:16];
        cand_dec    = decode(cand_ins);
        cand_hazard = load_valid_q & ((cand_dec.uses_rs & (cand_rs == load_rt_q)) |
                                      (cand_dec.uses_rt & (cand_rt == load_rt_q)));

        valid_d      = valid_q;
        stall_d      = stall_q;
        con_d        = con_q;
        ins_d        = ins_q;
        pc_d         = pc_q;
        skid_valid_d = skid_valid_q;
        skid_ins_d   = skid_ins_q;
        skid_pc_d    = skid_pc_q;
        cnt_d        = cnt_q;
        load_valid_d = load_valid_q;
        load_rt_d    = load_rt_q;
        trap_d       = trap_q;
        issue        = 1'b0;
        bubble       = 1'b0;

        if (flush) begin
            valid_d      = 1'b0;
            stall_d      = 1'b0;
            con_d        = CON_NOP;
            ins_d        = '0;
            pc_d         = '0;
            skid_valid_d = 1'b0;
            cnt_d        = '0;
            load_valid_d = 1'b0;
            trap_d       = 1'b0;
        end else if (cnt_q != '0) begin
            // Bubble in the output stage; the held word issues on the last bubble's transfer.
            if (out_xfer) begin
                if (cnt_q == CNT_W'(1)) begin
                    issue = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
        end else if (cand_valid && out_free) begin
            if (cand_hazard) begin
                bubble = 1'b1;
            end else begin
                issue = 1'b1;
            end
        end else if (in_xfer) begin
            skid_valid_d = 1'b1;
            skid_ins_d   = in_ins;
            skid_pc_d    = in_pc;
        end else if (out_xfer) begin
            valid_d = 1'b0;
            stall_d = 1'b0;
        end

        if (issue) begin
            valid_d      = 1'b1;
            stall_d      = 1'b0;
            con_d        = cand_dec.con;
            ins_d        = cand_ins;
            pc_d         = cand_pc;
            skid_valid_d = 1'b0;
            cnt_d        = '0;
            load_valid_d = cand_dec.is_lw & (cand_rt != 5'd0);
            load_rt_d    = cand_rt;
            trap_d       = TRAP_EN & ~cand_dec.legal;
        end
        if (bubble) begin
            valid_d      = 1'b1;
            stall_d      = 1'b1;
            con_d        = CON_NOP;
            ins_d        = '0;
            pc_d         = cand_pc;
            cnt_d        = CNT_W'(STALL_CYCLES);
            skid_valid_d = 1'b1;
            skid_ins_d   = cand_ins;
            skid_pc_d    = cand_pc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q      <= 1'b0;
            stall_q      <= 1'b0;
            con_q        <= CON_NOP;
            ins_q        <= '0;
            pc_q         <= '0;
            skid_valid_q <= 1'b0;
            skid_ins_q   <= '0;
            skid_pc_q    <= '0;
            cnt_q        <= '0;
            load_valid_q <= 1'b0;
            load_rt_q    <= 5'd0;
            trap_q       <= 1'b0;
            alive_q      <= 1'b0;
        end else begin
            valid_q      <= valid_d;
            stall_q      <= stall_d;
            con_q        <= con_d;
            ins_q        <= ins_d;
            pc_q         <= pc_d;
            skid_valid_q <= skid_valid_d;
            skid_ins_q   <= skid_ins_d;
            skid_pc_q    <= skid_pc_d;
            cnt_q        <= cnt_d;
            load_valid_q <= load_valid_d;
            load_rt_q    <= load_rt_d;
            trap_q       <= trap_d;
            alive_q      <= 1'b1;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: decode table plus throughput, backpressure, hazard, flush,
// illegal-word and asynchronous-reset sequences.
module tb_decode_stage;

    localparam logic [19:0] NOP_C  = 20'h06000;
    localparam logic [19:0] ADD_C  = 20'hA0000;
    localparam logic [19:0] LW_C   = 20'h80C80;
    localparam logic [31:0] ADD_W  = 32'h00221820;
    localparam logic [31:0] LW_W   = 32'h8C220000;
    localparam logic [31:0] ADDD_W = 32'h00441820;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_ins;
    logic [31:0] in_pc;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [19:0] out_controls;
    logic [31:0] out_ins;
    logic [31:0] out_pc;
    logic        stall;
`ifdef DECODE_ILLEGAL_TRAP_EN
    logic        illegal;
`endif

    int n_vec  = 0;
    int n_miss = 0;
    int xfers  = 0;

    decode_stage dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_ins       (in_ins),
        .in_pc        (in_pc),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_controls (out_controls),
        .out_ins      (out_ins),
        .out_pc       (out_pc),
        .stall        (stall)
`ifdef DECODE_ILLEGAL_TRAP_EN
        ,
        .illegal      (illegal)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (out_valid && out_ready) xfers <= xfers + 1;
    end

    typedef struct {
        logic [31:0] ins;
        logic [19:0] con;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int i);
        @(negedge clk);
        in_valid  = 1'b1;
        in_ins    = tbl[i].ins;
        in_pc     = 32'h1000 + 32'(i * 4);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk($sformatf("vec%0d valid", i), 32'(out_valid), 32'd1);
        chk($sformatf("vec%0d controls", i), 32'(out_controls), 32'(tbl[i].con));
        chk($sformatf("vec%0d ins", i), out_ins, tbl[i].ins);
        chk($sformatf("vec%0d stall", i), 32'(stall), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic lw_add_pair(input string tag);
        int x0;
        x0 = xfers;
        @(negedge clk);
        in_valid  = 1'b1;
        in_ins    = LW_W;
        in_pc     = 32'h200;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk({tag, " lw controls"}, 32'(out_controls), 32'(LW_C));
        in_ins = ADDD_W;
        in_pc  = 32'h204;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk({tag, " bubble valid"}, 32'(out_valid), 32'd1);
        chk({tag, " bubble stall"}, 32'(stall), 32'd1);
        chk({tag, " bubble controls"}, 32'(out_controls), 32'(NOP_C));
        chk({tag, " in_ready in bubble"}, 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        chk({tag, " add stall"}, 32'(stall), 32'd0);
        chk({tag, " add controls"}, 32'(out_controls), 32'(ADD_C));
        chk({tag, " add ins"}, out_ins, ADDD_W);
        @(posedge clk);
        #1;
        chk({tag, " drained"}, 32'(out_valid), 32'd0);
        chk({tag, " transfers"}, 32'(xfers - x0), 32'd3);
    endtask

    task automatic illegal_word(input logic [31:0] w);
        @(negedge clk);
        in_valid  = 1'b1;
        in_ins    = w;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("undecoded valid", 32'(out_valid), 32'd1);
        chk("undecoded controls", 32'(out_controls), 32'(NOP_C));
        chk("undecoded ins", out_ins, w);
`ifdef DECODE_ILLEGAL_TRAP_EN
        chk("illegal set", 32'(illegal), 32'd1);
        @(posedge clk);
        #1;
        chk("trap in_ready", 32'(in_ready), 32'd0);
        chk("illegal held", 32'(illegal), 32'd1);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("illegal cleared", 32'(illegal), 32'd0);
        chk("in_ready after flush", 32'(in_ready), 32'd1);
`else
        @(posedge clk);
        #1;
        chk("in_ready after undecoded", 32'(in_ready), 32'd1);
`endif
        run_vec(0);
    endtask

    initial begin
        tbl[0]  = '{32'h00221820, 20'hA0000};  // ADD
        tbl[1]  = '{32'h00221822, 20'hA2000};  // SUB
        tbl[2]  = '{32'h00221824, 20'hA4000};  // AND
        tbl[3]  = '{32'h00221825, 20'hA6000};  // OR
        tbl[4]  = '{32'h0022182A, 20'hA8000};  // SLT
        tbl[5]  = '{32'h2022FFFF, 20'h80800};  // ADDI
        tbl[6]  = '{32'h342200FF, 20'h87000};  // ORI
        tbl[7]  = '{32'hAC220004, 20'h00E00};  // SW
        tbl[8]  = '{32'h10220003, 20'h02010};  // BEQ
        tbl[9]  = '{32'h14220003, 20'h02020};  // BNE
        tbl[10] = '{32'h08000010, 20'h00030};  // J
        tbl[11] = '{32'h8C250000, 20'h80C80};  // LW $5, followed by an independent ADD

        rst = 1'b1; in_valid = 1'b0; in_ins = '0; in_pc = '0; flush = 1'b0; out_ready = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("reset valid", 32'(out_valid), 32'd0);
        chk("reset controls", 32'(out_controls), 32'(NOP_C));
        chk("reset ins", out_ins, 32'd0);
        chk("reset pc", out_pc, 32'd0);
        chk("reset stall", 32'(stall), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("in_ready after reset", 32'(in_ready), 32'd1);

        for (int i = 0; i < 12; i++) run_vec(i);
        run_vec(0);

        // Back-to-back issue.
        @(negedge clk);
        in_valid = 1'b1; in_ins = ADD_W; in_pc = 32'h10; out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("tput first valid", 32'(out_valid), 32'd1);
        chk("tput first controls", 32'(out_controls), 32'(ADD_C));
        chk("tput in_ready", 32'(in_ready), 32'd1);
        in_pc = 32'h14;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("tput second valid", 32'(out_valid), 32'd1);
        chk("tput second pc", out_pc, 32'h14);
        chk("tput stall", 32'(stall), 32'd0);
        @(posedge clk);
        #1;
        chk("tput drained", 32'(out_valid), 32'd0);

        // Backpressure: output register, skid, then intake blocked.
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; in_ins = 32'h00221820; in_pc = 32'h100;
        @(posedge clk);
        #1;
        chk("bp w1 held", out_ins, 32'h00221820);
        chk("bp in_ready after 1", 32'(in_ready), 32'd1);
        in_ins = 32'h00221822; in_pc = 32'h104;
        @(posedge clk);
        #1;
        chk("bp in_ready after 2", 32'(in_ready), 32'd0);
        chk("bp w1 stable", out_ins, 32'h00221820);
        in_ins = 32'h00221824; in_pc = 32'h108;
        @(posedge clk);
        #1;
        chk("bp w1 stable 3", out_pc, 32'h100);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp w2 out", out_ins, 32'h00221822);
        chk("bp in_ready release", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("bp w3 out", out_ins, 32'h00221824);
        chk("bp w3 pc", out_pc, 32'h108);
        @(posedge clk);
        #1;
        chk("bp drained", 32'(out_valid), 32'd0);

        lw_add_pair("hazard");

        // Flush with a held word and a pending bubble count.
        @(negedge clk);
        in_valid = 1'b1; in_ins = LW_W; out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_ins = ADDD_W;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("flush pre stall", 32'(stall), 32'd1);
        out_ready = 1'b0;
        flush = 1'b1;
        @(posedge clk);
        #1;
        chk("flush valid", 32'(out_valid), 32'd0);
        chk("flush stall", 32'(stall), 32'd0);
        chk("flush in_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1; in_ins = ADD_W;
        @(posedge clk);
        #1;
        chk("flush drops word", 32'(out_valid), 32'd0);
        flush = 1'b0;
        in_ins = ADDD_W; out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("flush cleared tracking", 32'(stall), 32'd0);
        chk("post flush add", 32'(out_controls), 32'(ADD_C));
        @(posedge clk);
        #1;
        lw_add_pair("post flush");

        illegal_word(32'hFC000000);
        illegal_word(32'h00221821);

        // Asynchronous reset while a word is held.
        @(negedge clk);
        in_valid = 1'b1; in_ins = ADD_W; out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("pre reset valid", 32'(out_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("async reset valid", 32'(out_valid), 32'd0);
        chk("async reset controls", 32'(out_controls), 32'(NOP_C));
        chk("async reset ins", out_ins, 32'd0);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("in_ready after async reset", 32'(in_ready), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered, handshaked successor to the combinational instruction decoder.
- Sits between IF and EX. Accepts a fetched instruction word and emits the `CON_MSB:`CON_LSB control word from defines.vh, plus the instruction and its PC.
- Adds a one-entry skid buffer, flush, and load-use hazard interlock with a parametrised bubble count.
- Decodes a wider instruction subset than the base ADD-only decoder.

Parameters:
- INS_W, 32, instruction/PC width.
- CON_W, `CON_MSB-`CON_LSB+1 (20), control word width.
- STALL_CYCLES, 1, bubbles inserted on load-use hazard (1..7).
- CNT_W, 3, width of stall counter; must hold STALL_CYCLES.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- in_valid  in  1  instruction word valid.
- in_ready  out  1  stage can accept instruction this cycle.
- in_ins  in  INS_W  raw instruction.
- in_pc  in  INS_W  PC of in_ins.
- flush  in  1  discard all held and incoming instructions (branch taken).
- out_valid  out  1  controls/out_ins valid.
- out_ready  in  1  EX accepts this cycle.
- out_controls  out  CON_W  decoded control word.
- out_ins  out  INS_W  instruction matching out_controls.
- out_pc  out  INS_W  PC matching out_controls.
- stall  out  1  hazard bubble being emitted this cycle.

Behaviour:
- Reset (async, immediate):
  - out_valid=0, stall=0, skid empty, stall counter=0, last-load tracking cleared.
  - out_controls = default NOP word (MEM_CS_DISABLE, REG_WRITE_EN_F, ALU_OP_OR, all other fields at their default selects).
  - out_ins=0, out_pc=0, in_ready=1 one cycle after rst deasserts.
- Decode is combinational on the accepted word and registered into the output stage, so latency is 1 cycle from acceptance to out_valid.
- Decoded set:
  - R-type by funct: ADD, SUB, AND, OR, SLT.
  - I-type: ADDI (sign ext), ORI (zero ext), LW, SW, BEQ, BNE.
  - J.
  - Any other encoding gives the NOP word with out_valid=1.
- Handshakes:
  - Transfer in occurs when in_valid & in_ready.
  - Transfer out occurs when out_valid & out_ready.
  - in_ready = skid empty & stall counter == 0.
  - If the output register is full and out_ready=0, an accepted word goes to the skid. The skid drains into the output register on the next out transfer.
  - Output fields are stable while out_valid & !out_ready.
- Load-use hazard:
  - Track rt of the last instruction transferred out if it was LW and rt != 0.
  - If the word about to enter the output register reads that register (rs, or rt for R-type/SW/BEQ/BNE), the word is held in the skid and the counter loads STALL_CYCLES.
  - While the counter is nonzero: emit the NOP word with out_valid=1 and stall=1. The counter decrements on each out transfer.
  - When the counter reaches 0, the held word issues. Tracking clears after the bubbles.
- Flush:
  - Clears out_valid, skid, counter and load tracking next edge.
  - A word presented in the same cycle as flush is dropped.
  - Flush has priority over every simultaneous event.
- Register 0 never triggers a hazard.
- Simultaneous out transfer and in transfer with an empty skid: the new word replaces the output register the same edge (full throughput, 1 instr/cycle).

Optional Feature:
- Macro: DECODE_ILLEGAL_TRAP_EN.
- When defined:
  - An extra output illegal (1 bit, reset 0) is added.
  - An undecoded instruction asserts illegal together with out_valid, carrying the NOP controls.
  - The stage then deasserts in_ready until flush or rst. illegal stays asserted until then.
- When undefined:
  - No illegal port exists.
  - Undecoded words silently become NOPs and the pipeline continues.

Test Plan:
- Reset mid-stream: rst pulses while out_valid=1 -> out_valid=0 and out_controls=NOP immediately, without waiting for clk.
- Throughput: ADD $3,$1,$2 (0x00221820) then 0x00221820 again, back-to-back, out_ready=1 -> out_valid on cycles 1,2. REG_WRITE_EN_T, ALU_OP_ADD. stall=0.
- Backpressure: three words are sent while out_ready=0 for 3 cycles -> the first is held in the output register and the second in the skid. in_ready=0 after two transfers. The order is preserved after release.
- Load-use: LW $2,0($1) (0x8C220000) then ADD $3,$2,$4 (0x00441820), STALL_CYCLES=1 -> LW out, then one NOP with stall=1, then ADD. Total 3 out transfers.
- Flush: flush asserts with a word in the skid and a pending hazard -> next cycle out_valid=0, counter=0. The following LW/ADD pair re-triggers the hazard normally.
- Illegal word 0xFC000000:
  - With DECODE_ILLEGAL_TRAP_EN, illegal=1 and in_ready=0 until flush.
  - Without it, a NOP is emitted and the next word is accepted.
